// File: rtl/encrypt_process.sv
// ACORN-128 encryption stage: absorbs a 128-bit plaintext block, one state-update
// step per clock over 384 steps (128 data, one padding '1', 255 zero steps).
module encrypt_process (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [292:0] state_in,
  input  logic [127:0] pt_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] ct_out,
  output logic [292:0] state_out
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         st, st_nxt;
  logic [292:0] s, u, s_nxt;
  logic [127:0] p;
  logic [8:0]   cnt;
  logic         last, m, ca, ks, f;

  assign last = (cnt == 9'd383);

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else     st <= st_nxt;

  // next state
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: if (start) st_nxt = RUN;
      RUN:  if (last)  st_nxt = IDLE;
      default:         st_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy      = (st == RUN);
    state_out = s;
  end

  // Step inputs: data bits for 0..127, padding '1' at 128, zeros after;
  // ca drops at step 256. cb is zero for the whole stage so its term is dropped.
  always_comb begin
    m  = (cnt < 9'd128) ? p[cnt[6:0]] : (cnt == 9'd128);
    ca = ~cnt[8];
  end

  // One step; each LFSR fold sees the folds above it already applied.
  always_comb begin
    u      = s;
    u[289] = u[289] ^ u[235] ^ u[230];
    u[230] = u[230] ^ u[196] ^ u[193];
    u[193] = u[193] ^ u[160] ^ u[154];
    u[154] = u[154] ^ u[111] ^ u[107];
    u[107] = u[107] ^ u[66]  ^ u[61];
    u[61]  = u[61]  ^ u[23]  ^ u[0];
    ks     = u[12] ^ u[154] ^ maj(u[235], u[61], u[193]) ^ ch(u[230], u[111], u[66]);
    f      = u[0] ^ ~u[107] ^ maj(u[244], u[23], u[160]) ^ (ca & u[196]);
    s_nxt  = {f ^ m, u[292:1]};
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s      <= '0;
      p      <= '0;
      cnt    <= '0;
      ct_out <= '0;
      done   <= 1'b0;
    end else begin
      done <= (st == RUN) && last;
      if (st == IDLE && start) begin
        s      <= state_in;
        p      <= pt_in;
        cnt    <= '0;
        ct_out <= '0;
      end else if (st == RUN) begin
        s   <= s_nxt;
        cnt <= last ? 9'd0 : cnt + 9'd1;
        if (cnt[8:7] == 2'b00) ct_out[cnt[6:0]] <= p[cnt[6:0]] ^ ks;
      end
    end

endmodule
